// File: rtl/bram_be_port_client.sv
// Request/response initiator for one port of a byte-enabled block RAM.
// Read data is tracked through the RAM latency and returned in order via a credit-protected FIFO.
module bram_be_port_client #(
    parameter int unsigned PIPELINED  = 0,
    parameter int unsigned ADDR_WIDTH = 1,
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned CHUNKSIZE  = 1,
    parameter int unsigned WE_WIDTH   = 1,
    parameter int unsigned RSP_DEPTH  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [WE_WIDTH-1:0]   i_req_we,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_data,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic                  o_en,
    output logic [WE_WIDTH-1:0]   o_we,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_di,
    input  logic [DATA_WIDTH-1:0] i_do
);

    localparam int unsigned LAT   = PIPELINED + 1;
    localparam int unsigned PTR_W = $clog2(RSP_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_DEPTH);

    logic                  w_accept;
    logic                  w_rd_accept;
    logic                  w_push;
    logic                  w_pop;
    logic [LAT-1:0]        w_tag_d;
    logic [CNT_W-1:0]      w_cnt_d;
    logic [CNT_W-1:0]      w_fifo_cnt_d;

    logic [LAT-1:0]        r_tag;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      r_fifo_cnt;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_mem [RSP_DEPTH];

    // Credits cover queued plus in-flight reads, so a captured DO always has a free slot.
    assign o_req_ready = !i_rst && (r_cnt < DEPTH_C);
    assign w_accept    = i_req_valid && o_req_ready;
    assign w_rd_accept = w_accept && (i_req_we == '0);
    assign w_push      = r_tag[LAT-1];
    assign w_pop       = (r_fifo_cnt != '0) && i_rsp_ready;

    assign o_en   = w_accept;
    assign o_we   = w_accept ? i_req_we : '0;
    assign o_addr = i_req_addr;

    for (genvar g_lane = 0; g_lane < WE_WIDTH; g_lane++) begin : g_di_lane
        assign o_di[g_lane*CHUNKSIZE +: CHUNKSIZE] = i_req_data[g_lane*CHUNKSIZE +: CHUNKSIZE];
    end

    assign o_rsp_valid = (r_fifo_cnt != '0);
    assign o_rsp_data  = r_mem[r_rd_ptr];

    always_comb begin
        w_tag_d      = r_tag << 1;
        w_tag_d[0]   = w_rd_accept;
        w_cnt_d      = r_cnt;
        w_fifo_cnt_d = r_fifo_cnt;
        if (w_rd_accept && !w_pop) begin
            w_cnt_d = r_cnt + CNT_W'(1);
        end else if (!w_rd_accept && w_pop) begin
            w_cnt_d = r_cnt - CNT_W'(1);
        end
        if (w_push && !w_pop) begin
            w_fifo_cnt_d = r_fifo_cnt + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_fifo_cnt_d = r_fifo_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tag      <= '0;
            r_cnt      <= '0;
            r_fifo_cnt <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_tag      <= w_tag_d;
            r_cnt      <= w_cnt_d;
            r_fifo_cnt <= w_fifo_cnt_d;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_do;
        end
    end

endmodule
